// File: rtl/video_period_scheduler.sv
// video_period_scheduler
//
// Raster timing generator for a TMDS-style video transmitter. Walks an
// (x, y) position across a H_TOTAL x V_TOTAL raster and classifies every
// position into a data-island period: CTRL, PREAMBLE, GUARD or VIDEO.
// A small IDLE / RUN / DRAIN controller starts the raster from a fixed
// home position and lets the current frame finish before parking again,
// so a frame is never truncated by the run request.
//
// Ports
//   pixclk      : pixel clock, all state on the rising edge
//   reset       : asynchronous active-high reset
//   run         : request to generate video
//   pix_valid   : pixel source has data this cycle
//   x, y        : current raster position (10 bits each)
//   hsync/vsync : sync outputs, asserted level is SYNC_POL
//   period      : 0=CTRL, 1=PREAMBLE, 2=GUARD, 3=VIDEO
//   ctl         : CTL3..CTL0 for channels 1/2 (4'b0001 during PREAMBLE)
//   pix_req     : a pixel is consumed this cycle
//   frame_start : one-cycle pulse when (x, y) = (0, 0)
//   busy        : controller is not IDLE
//   underrun    : sticky pixel-starvation flag
//
// Pixel handshake: pix_req is the consumer strobe and pix_valid the
// producer's data-present flag. A pixel transfers on every rising edge
// where both are high; pix_req never waits for pix_valid (the raster cannot
// stall), so an edge with pix_req=1 and pix_valid=0 is a starvation event
// that sets underrun until reset or the next IDLE to RUN transition.
//
// Every output is a register loaded from the decode of the next-state
// counters, so x/y and all the flags describe the same position on the
// same cycle.

module video_period_scheduler #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic       pixclk,
  input  logic       reset,
  input  logic       run,
  input  logic       pix_valid,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic [1:0] period,
  output logic [3:0] ctl,
  output logic       pix_req,
  output logic       frame_start,
  output logic       busy,
  output logic       underrun
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  // Home: first blanking pixel of the last line. Starting here gives a
  // full preamble and guard on the last line before line 0 of the frame.
  localparam logic [9:0] HOME_X  = 10'(H_ACTIVE);
  localparam logic [9:0] HOME_Y  = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST  = 10'(V_TOTAL - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] PER_CTRL     = 2'd0;
  localparam logic [1:0] PER_PREAMBLE = 2'd1;
  localparam logic [1:0] PER_GUARD    = 2'd2;
  localparam logic [1:0] PER_VIDEO    = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [9:0] x_adv;
  logic [9:0] y_adv;
  logic       adv_home;
  logic [9:0] x_nx;
  logic [9:0] y_nx;

  // Counter advance and controller next state.
  always_comb begin
    x_adv    = (x == X_LAST) ? 10'd0 : x + 10'd1;
    y_adv    = y;
    if (x == X_LAST) begin
      y_adv = (y == Y_LAST) ? 10'd0 : y + 10'd1;
    end
    adv_home = (x_adv == HOME_X) && (y_adv == HOME_Y);

    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    case (state)
      ST_IDLE: begin
        // Counters stay parked this cycle; they move from the next one.
        if (run) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        x_nx = x_adv;
        y_nx = y_adv;
        // Dropping run exactly as the raster reaches home means the frame
        // is already complete, so park directly instead of draining a
        // whole extra frame.
        if (!run) begin
          state_nx = adv_home ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        x_nx = x_adv;
        y_nx = y_adv;
        if (run) begin
          state_nx = ST_RUN;
        end else if (adv_home) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        x_nx     = HOME_X;
        y_nx     = HOME_Y;
      end
    endcase
  end

  // Decode of the next-state position.
  logic       active_nx;
  logic       hs_on_nx;
  logic       vs_on_nx;
  logic       pre_line_nx;
  logic [1:0] period_nx;
  int         xi;
  int         yi;

  always_comb begin
    xi          = int'(x_nx);
    yi          = int'(y_nx);
    active_nx   = (state_nx != ST_IDLE);
    hs_on_nx    = active_nx && (xi >= HS_START) && (xi < HS_END);
    vs_on_nx    = active_nx && (yi >= VS_START) && (yi < VS_END);
    // The line just before an active line carries the preamble/guard.
    pre_line_nx = (yi == V_TOTAL - 1) || (yi + 1 < V_ACTIVE);
    period_nx   = PER_CTRL;
    if (active_nx) begin
      if ((xi < H_ACTIVE) && (yi < V_ACTIVE)) begin
        period_nx = PER_VIDEO;
      end else if (pre_line_nx && (xi >= H_TOTAL - 10) && (xi <= H_TOTAL - 3)) begin
        period_nx = PER_PREAMBLE;
      end else if (pre_line_nx && (xi >= H_TOTAL - 2)) begin
        period_nx = PER_GUARD;
      end
    end
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      x           <= HOME_X;
      y           <= HOME_Y;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      period      <= PER_CTRL;
      ctl         <= 4'b0000;
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_nx;
      x           <= x_nx;
      y           <= y_nx;
      hsync       <= hs_on_nx ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_on_nx ? SYNC_POL : ~SYNC_POL;
      period      <= period_nx;
      ctl         <= (period_nx == PER_PREAMBLE) ? 4'b0001 : 4'b0000;
      pix_req     <= (period_nx == PER_VIDEO);
      frame_start <= active_nx && (x_nx == 10'd0) && (y_nx == 10'd0);
      busy        <= active_nx;
      if ((state == ST_IDLE) && run) begin
        underrun <= 1'b0;
      end else if (pix_req && !pix_valid) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_period_scheduler.sv
// Bench for video_period_scheduler on a reduced raster:
//   H: 16 active, 2 fp, 4 sync, 10 bp -> H_TOTAL 32
//   V:  6 active, 1 fp, 2 sync,  1 bp -> V_TOTAL 10, frame = 320 cycles
//   SYNC_POL = 0, home = (16, 9)
// A cycle model pushes the expected output word after every rising edge;
// a monitor pops and compares it 2 ns after the edge. The directed
// sequence adds hand-computed checks on timing landmarks.

module tb_video_period_scheduler;

  localparam int   HA  = 16;
  localparam int   HFP = 2;
  localparam int   HS  = 4;
  localparam int   HBP = 10;
  localparam int   VA  = 6;
  localparam int   VFP = 1;
  localparam int   VS  = 2;
  localparam int   VBP = 1;
  localparam int   HT  = HA + HFP + HS + HBP;
  localparam int   VT  = VA + VFP + VS + VBP;
  localparam logic SP  = 1'b0;

  // Reset/idle word: x=16, y=9, syncs at 1 (deasserted), rest 0.
  localparam logic [31:0] HOME_VEC = {10'd16, 10'd9, 1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

  // ---------------- clock / reset ----------------
  logic pixclk = 1'b0;
  logic reset  = 1'b1;
  logic run    = 1'b0;
  logic pix_valid = 1'b1;

  always #5 pixclk = ~pixclk;

  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic [1:0] period;
  logic [3:0] ctl;
  logic       pix_req;
  logic       frame_start;
  logic       busy;
  logic       underrun;
  logic [31:0] dut_vec;

  assign dut_vec = {x, y, hsync, vsync, period, ctl, pix_req, frame_start, busy, underrun};

  video_period_scheduler #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(SP)
  ) dut (
    .pixclk(pixclk),
    .reset(reset),
    .run(run),
    .pix_valid(pix_valid),
    .x(x),
    .y(y),
    .hsync(hsync),
    .vsync(vsync),
    .period(period),
    .ctl(ctl),
    .pix_req(pix_req),
    .frame_start(frame_start),
    .busy(busy),
    .underrun(underrun)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_st  = 0;   // 0 idle, 1 run, 2 drain
  int   mx    = HA;
  int   my    = VT - 1;
  int   ax;
  int   ay;
  logic m_und  = 1'b0;
  logic m_preq = 1'b0;
  logic [31:0] m_vec;

  function automatic logic [31:0] model_out(input int st, input int px, input int py, input logic und);
    logic       bz;
    logic       hs;
    logic       vs;
    logic       pre;
    logic [1:0] per;
    logic [3:0] c;
    bz  = (st != 0);
    hs  = (bz && px >= HA + HFP && px < HA + HFP + HS) ? SP : ~SP;
    vs  = (bz && py >= VA + VFP && py < VA + VFP + VS) ? SP : ~SP;
    pre = (((py + 1) % VT) < VA);
    per = 2'd0;
    if (bz) begin
      if (px < HA && py < VA) per = 2'd3;
      else if (pre && px >= HT - 10 && px <= HT - 3) per = 2'd1;
      else if (pre && px >= HT - 2) per = 2'd2;
    end
    c = (per == 2'd1) ? 4'b0001 : 4'b0000;
    return {10'(px), 10'(py), hs, vs, per, c, (per == 2'd3), (bz && px == 0 && py == 0), bz, und};
  endfunction

  always @(posedge pixclk) begin
    if (reset) begin
      m_st  = 0;
      mx    = HA;
      my    = VT - 1;
      m_und = 1'b0;
    end else if (m_st == 0) begin
      if (run) begin
        m_st  = 1;
        m_und = 1'b0;
      end
    end else begin
      if (m_preq && !pix_valid) m_und = 1'b1;
      ax = (mx + 1) % HT;
      ay = (ax == 0) ? (my + 1) % VT : my;
      mx = ax;
      my = ay;
      if (run) m_st = 1;
      else if (mx == HA && my == VT - 1) m_st = 0;
      else m_st = 2;
    end
    m_vec  = model_out(m_st, mx, my, m_und);
    m_preq = m_vec[3];
    exp_q.push_back(m_vec);
  end

  // ---------------- monitor ----------------
  always @(posedge pixclk) begin
    #2;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL monitor at %0t: output present, expected queue empty", $time);
    end else begin
      check("cycle_outputs", dut_vec, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge pixclk);
  endtask

  task automatic wait_pos(input int tx, input int ty, input int budget, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge pixclk);
      if (int'(x) == tx && int'(y) == ty) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Runs from IDLE-with-run up to the first frame_start, recording the
  // first preamble/guard positions and the cycle count from RUN entry.
  task automatic measure_startup(input string tag);
    int pre_x;
    int pre_y;
    int grd_x;
    int fs_cyc;
    pre_x = -1; pre_y = -1; grd_x = -1; fs_cyc = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge pixclk);
      if (period == 2'd1 && pre_x < 0) begin
        pre_x = int'(x);
        pre_y = int'(y);
      end
      if (period == 2'd2 && grd_x < 0) grd_x = int'(x);
      if (frame_start) begin
        fs_cyc = k;
        break;
      end
    end
    check({tag, "_first_preamble_x"}, 32'(pre_x), 32'd22);
    check({tag, "_first_preamble_y"}, 32'(pre_y), 32'd9);
    check({tag, "_first_guard_x"}, 32'(grd_x), 32'd30);
    check({tag, "_frame_start_cycle"}, 32'(fs_cyc), 32'd17);
  endtask

  // Starting on a frame_start cycle, counts one frame.
  task automatic measure_frame(input string tag);
    int cnt;
    int preq;
    int hs_on;
    int vs_on;
    cnt = 0; preq = 0; hs_on = 0; vs_on = 0;
    do begin
      if (pix_req) preq++;
      if (hsync == SP) hs_on++;
      if (vsync == SP) vs_on++;
      @(negedge pixclk);
      cnt++;
    end while (!frame_start && cnt < 1000);
    check({tag, "_frame_period"}, 32'(cnt), 32'd320);
    check({tag, "_pix_req_count"}, 32'(preq), 32'd96);
    check({tag, "_hsync_cycles"}, 32'(hs_on), 32'd40);
    check({tag, "_vsync_cycles"}, 32'(vs_on), 32'd64);
  endtask

  task automatic wait_idle(input string tag, output int cycles, output int preq);
    cycles = 0;
    preq   = 0;
    while (busy && cycles < 1000) begin
      @(negedge pixclk);
      cycles++;
      if (pix_req) preq++;
    end
    check({tag, "_busy_fell"}, 32'(busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int drain_cyc;
  int drain_preq;
  int idle_preq;
  int busy_low;

  initial begin
    reset = 1'b1; run = 1'b0; pix_valid = 1'b1;
    step(3);
    check("reset_state", dut_vec, HOME_VEC);
    reset = 1'b0;
    step(4);
    check("idle_hold", dut_vec, HOME_VEC);

    // Start-up from home and two free-running frames.
    run = 1'b1;
    measure_startup("start");
    measure_frame("frame1");
    measure_frame("frame2");
    check("underrun_clean", 32'(underrun), 32'd0);

    // One starved pixel at (5,2).
    wait_pos(5, 2, 400, "wait_5_2");
    check("underrun_before", 32'(underrun), 32'd0);
    pix_valid = 1'b0;
    step(1);
    pix_valid = 1'b1;
    check("underrun_set", 32'(underrun), 32'd1);

    // Drop run at (0,3): 208 more cycles to home, 47 pixels left.
    wait_pos(0, 3, 400, "wait_0_3");
    run = 1'b0;
    wait_idle("drain", drain_cyc, drain_preq);
    check("drain_cycles", 32'(drain_cyc), 32'd208);
    check("drain_pix_req", 32'(drain_preq), 32'd47);
    check("drain_home_x", 32'(x), 32'd16);
    check("drain_home_y", 32'(y), 32'd9);
    check("underrun_sticky", 32'(underrun), 32'd1);
    idle_preq = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge pixclk);
      if (pix_req) idle_preq++;
    end
    check("idle_no_pix_req", 32'(idle_preq), 32'd0);

    // Restart clears underrun.
    run = 1'b1;
    step(1);
    check("restart_underrun_clear", 32'(underrun), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_x_home", 32'(x), 32'd16);

    // Run dropped at y=1, reasserted at y=4: busy never falls.
    wait_pos(0, 1, 400, "wait_0_1");
    run = 1'b0;
    busy_low = 0;
    for (int i = 0; i < 3 * HT; i++) begin
      @(negedge pixclk);
      if (!busy) busy_low++;
    end
    check("toggle_at_y4_x", 32'(x), 32'd0);
    check("toggle_at_y4_y", 32'(y), 32'd4);
    run = 1'b1;
    for (int i = 0; i < 2 * HT; i++) begin
      @(negedge pixclk);
      if (!busy) busy_low++;
    end
    check("toggle_busy_low", 32'(busy_low), 32'd0);

    // Asynchronous reset mid-line at (8,4).
    wait_pos(8, 4, 400, "wait_8_4");
    #1 reset = 1'b1;
    #1 check("async_reset", dut_vec, HOME_VEC);
    step(2);
    check("reset_held", dut_vec, HOME_VEC);
    reset = 1'b0;
    measure_startup("after_reset");

    run = 1'b0;
    wait_idle("final", drain_cyc, drain_preq);
    check("final_home", dut_vec, {HOME_VEC[31:2], 1'b0, 1'b0});
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/video_period_scheduler.md
VIDEO_PERIOD_SCHEDULER -- requirements
Module: video_period_scheduler

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 1, asserted level of hsync/vsync
REQ-002 SHALL have ports (name, direction, width, meaning), one per line, clock and reset first; one clock, asynchronous active-high reset:
- pixclk, in, 1, pixel clock; all state on rising edge
- reset, in, 1, asynchronous active-high reset
- run, in, 1, request to generate video
- pix_valid, in, 1, pixel source has data this cycle
- x, out, 10, current horizontal position
- y, out, 10, current line
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- period, out, 2, 0=CTRL, 1=PREAMBLE, 2=GUARD, 3=VIDEO
- ctl, out, 4, CTL3..CTL0 for channels 1/2
- pix_req, out, 1, pixel consumed this cycle
- frame_start, out, 1, one-cycle pulse at (0,0)
- busy, out, 1, state is not IDLE
- underrun, out, 1, sticky pixel-starvation flag

Function
REQ-003 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP; legal configurations SHALL satisfy H_TOTAL<=1024, V_TOTAL<=1024 and H_BP>=10.
REQ-004 SHALL define the home position as x=H_ACTIVE, y=V_TOTAL-1.
REQ-005 SHALL implement states IDLE, RUN and DRAIN.
REQ-006 IDLE behaviour: counters held at home; period=CTRL; syncs deasserted; pix_req=0.
REQ-007 IDLE to RUN: when run=1; the counters advance starting the following cycle.
REQ-008 Counter advance in RUN/DRAIN:
- x increments every cycle and wraps H_TOTAL-1 to 0.
- y increments when x wraps, and wraps V_TOTAL-1 to 0.
REQ-009 RUN to DRAIN: when run=0.
REQ-010 DRAIN to RUN: when run=1, with no counter disturbance.
REQ-011 DRAIN to IDLE: on the cycle the counters would advance onto home, landing exactly on home.
REQ-012 All outputs SHALL be registered and describe the (x,y) presented on the same cycle, i.e. decoded from next-state counters, with zero skew between x/y and the other outputs.
REQ-013 hsync SHALL equal SYNC_POL for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, otherwise ~SYNC_POL.
REQ-014 vsync SHALL equal SYNC_POL for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, otherwise ~SYNC_POL.
REQ-015 period=VIDEO SHALL hold when x<H_ACTIVE and y<V_ACTIVE.
REQ-016 A pre-active line is one where (y+1) mod V_TOTAL < V_ACTIVE. On a pre-active line:
- period=PREAMBLE for H_TOTAL-10 <= x <= H_TOTAL-3.
- period=GUARD for x in {H_TOTAL-2, H_TOTAL-1}.
REQ-017 In every other position, period=CTRL.
REQ-018 ctl SHALL be 4'b0001 during PREAMBLE, otherwise 4'b0000.
REQ-019 pix_req SHALL equal (period==VIDEO) and be asserted for exactly H_ACTIVE*V_ACTIVE cycles per frame.
REQ-020 underrun SHALL set on any cycle with pix_req=1 and pix_valid=0, and hold until reset or the IDLE to RUN transition.
REQ-021 frame_start SHALL pulse exactly on the cycle x=0, y=0.
REQ-022 busy SHALL be 1 in RUN and DRAIN.
REQ-023 A run toggle mid-frame SHALL NOT truncate a frame; every started frame completes in full.

Reset
REQ-024 While reset=1, the block SHALL be in IDLE with x=H_ACTIVE, y=V_TOTAL-1, hsync=vsync=~SYNC_POL, period=0, ctl=0, pix_req=0, frame_start=0, busy=0, underrun=0.
REQ-025 Reset SHALL take effect immediately, including mid-line, and the first frame after release SHALL begin with a full PREAMBLE and GUARD.

Verification
REQ-026 Defaults, reset release, run=1, pix_valid=1:
- first preamble at x=790..797, y=524; guard at x=798..799.
- frame_start with x=0, y=0 on cycle 161 after RUN entry.
- 307200 pix_req cycles per frame; underrun stays 0.
REQ-027 Free-run two frames:
- hsync high x=656..751 on every line; vsync high y=490..491.
- frame period 420000 cycles.
REQ-028 run dropped at y=100:
- frame completes; DRAIN ends at x=640, y=524; busy falls.
- no further pix_req.
REQ-029 run dropped at y=100 and reasserted at y=300: continuous output, no counter discontinuity, busy stays 1.
REQ-030 pix_valid forced 0 for one cycle at (5,7): underrun=1 from the next cycle; remains 1 after DRAIN; cleared by the next IDLE to RUN transition.
REQ-031 reset asserted at x=320, y=240: outputs return to reset values asynchronously before the next pixclk edge.
